key_loader: RTL and testbench

KEY_LOADER -- requirements
Module: key_loader

---
 rtl/key_loader.sv | 113 +++++++++++
 tb/tb_key_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_loader.sv
// Serial-to-parallel key loader: shifts KEY_W bits MSB-first into a shadow register and commits them atomically to keyinput.
// Optional odd-parity check on a trailing bit is compiled in with `define KEY_PARITY_CHECK_EN.
module key_loader #(
  parameter int KEY_W = 16,
  parameter int TMO   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sdi,
  input  logic             sdi_vld,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);
  localparam int BCW = $clog2(KEY_W + 1);
  localparam int ICW = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, PAR, COMMIT, READY, ERR} state_t;

  state_t           state, nxt;
  logic [KEY_W-1:0] shadow;
  logic [BCW-1:0]   bitcnt;
  logic [ICW-1:0]   idlecnt;
  logic             last_bit, tmo_hit;

  assign last_bit = (bitcnt == BCW'(KEY_W - 1));
  // Fires on the TMO-th consecutive idle cycle, so idlecnt never exceeds TMO.
  assign tmo_hit  = (idlecnt == ICW'(TMO - 1));
  assign busy     = (state == SHIFT) || (state == PAR) || (state == COMMIT);

`ifdef KEY_PARITY_CHECK_EN
  logic par_ok;
  assign par_ok = ^{shadow, sdi};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (start) begin
      nxt = SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          if (sdi_vld) begin
`ifdef KEY_PARITY_CHECK_EN
            if (last_bit) nxt = PAR;
`else
            if (last_bit) nxt = COMMIT;
`endif
          end else if (tmo_hit) begin
            nxt = ERR;
          end
        end
`ifdef KEY_PARITY_CHECK_EN
        PAR: begin
          if (sdi_vld)      nxt = par_ok ? COMMIT : ERR;
          else if (tmo_hit) nxt = ERR;
        end
`endif
        COMMIT:  nxt = READY;
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      bitcnt    <= '0;
      idlecnt   <= '0;
      keyinput  <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else if (start) begin
      shadow    <= '0;
      bitcnt    <= '0;
      idlecnt   <= '0;
      keyinput  <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        SHIFT, PAR: begin
          if (sdi_vld) begin
            idlecnt <= '0;
            if (state == SHIFT) begin
              shadow <= {shadow[KEY_W-2:0], sdi};
              bitcnt <= bitcnt + BCW'(1);
            end
          end else begin
            idlecnt <= idlecnt + ICW'(1);
          end
        end
        COMMIT: begin
          keyinput  <= shadow;
          key_valid <= 1'b1;
        end
        default: ;
      endcase
      if (nxt == ERR && state != ERR) begin
        keyinput  <= '0;
        key_valid <= 1'b0;
        err       <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_key_loader.sv
// Randomized bench for key_loader with a per-cycle behavioural model and directed literal checks.
module tb_key_loader;
  localparam int KEY_W = 16;
  localparam int TMO   = 255;
`ifdef KEY_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sdi = 1'b0;
  logic             sdi_vld = 1'b0;
  logic [KEY_W-1:0] keyinput;
  logic             key_valid, busy, err;

  int checks = 0;
  int errors = 0;

  key_loader #(.KEY_W(KEY_W), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sdi(sdi), .sdi_vld(sdi_vld),
    .keyinput(keyinput), .key_valid(key_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a load is "active" while bits are still wanted; "pend" means the key appears next edge.
  bit m_act, m_pend, m_kv, m_err;
  int m_cnt, m_key, m_idle, m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 0; m_pend <= 0; m_kv <= 0; m_err <= 0;
      m_cnt <= 0; m_key <= 0; m_idle <= 0; m_out <= 0;
    end else if (start) begin
      m_act <= 1; m_pend <= 0; m_kv <= 0; m_err <= 0;
      m_cnt <= 0; m_key <= 0; m_idle <= 0; m_out <= 0;
    end else if (m_pend) begin
      m_out <= m_key; m_kv <= 1; m_pend <= 0;
    end else if (m_act) begin
      if (sdi_vld) begin
        m_idle <= 0;
        if (m_cnt < KEY_W) begin
          m_key <= (m_key * 2 + int'(sdi)) % (1 << KEY_W);
          m_cnt <= m_cnt + 1;
          if (m_cnt == KEY_W - 1 && !PAR_EN) begin
            m_act <= 0; m_pend <= 1;
          end
        end else begin
          m_act <= 0;
          if ((($countones(m_key) + int'(sdi)) % 2) == 1) m_pend <= 1;
          else m_err <= 1;
        end
      end else begin
        m_idle <= m_idle + 1;
        if (m_idle + 1 == TMO) begin
          m_act <= 0; m_err <= 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("cyc_keyinput", 32'(keyinput), 32'(m_out));
      chk("cyc_key_valid", 32'(key_valid), 32'(m_kv));
      chk("cyc_busy", 32'(busy), 32'(m_act | m_pend));
      chk("cyc_err", 32'(err), 32'(m_err));
    end
  end

  task automatic do_start(input bit v);
    @(negedge clk); start = 1; sdi_vld = v; sdi = 1'($urandom);
    @(negedge clk); start = 0; sdi_vld = 0;
  endtask

  // Sends w[hi] down to w[lo]; returns at the negedge right after the last bit's edge.
  task automatic send_bits(input logic [15:0] w, input int hi, input int lo, input int maxgap);
    for (int i = hi; i >= lo; i--) begin
      int gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        @(negedge clk); sdi_vld = 0; sdi = 1'($urandom);
      end
      @(negedge clk); sdi_vld = 1; sdi = w[i];
    end
    @(negedge clk); sdi_vld = 0;
  endtask

  task automatic send_par(input logic p);
    @(negedge clk); sdi_vld = 1; sdi = p;
    @(negedge clk); sdi_vld = 0;
  endtask

  // After the data bits: supply a good parity bit when configured, then let the commit edge pass.
  task automatic finish_load(input logic [15:0] w);
    if (PAR_EN) send_par(~^w);
    @(posedge clk); #2;
  endtask

  task automatic noise(input int n);
    repeat (n) begin
      @(negedge clk); sdi_vld = 1'($urandom); sdi = 1'($urandom);
    end
    @(negedge clk); sdi_vld = 0;
  endtask

  initial begin
    logic [15:0] w;
    #1; chk("rst_keyinput", 32'(keyinput), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Contiguous load of 0xA5C3
    w = 16'hA5C3;
    do_start(0);
    chk("start_busy", 32'(busy), 1);
    send_bits(w, 15, 0, 0);
    chk("bit16_key_valid_low", 32'(key_valid), 0);
    chk("bit16_busy", 32'(busy), 1);
    if (PAR_EN) begin
      send_par(1'b1);
      chk("par1_key_valid_low", 32'(key_valid), 0);
    end
    @(posedge clk); #2;
    chk("load_key", 32'(keyinput), 32'hA5C3);
    chk("load_key_valid", 32'(key_valid), 1);
    chk("load_busy_low", 32'(busy), 0);
    chk("load_err", 32'(err), 0);
    noise(6);
    chk("ready_ignores_sdi", 32'(keyinput), 32'hA5C3);

    if (PAR_EN) begin
      do_start(0);
      send_bits(w, 15, 0, 0);
      send_par(1'b0);
      chk("par0_err", 32'(err), 1);
      chk("par0_keyinput", 32'(keyinput), 0);
      chk("par0_key_valid", 32'(key_valid), 0);
      do_start(0);
      send_bits(w, 15, 0, 0);
      finish_load(w);
      chk("reload_key", 32'(keyinput), 32'hA5C3);
    end

    // Restart from READY, then load 0x1234
    do_start(0);
    chk("restart_key_valid", 32'(key_valid), 0);
    chk("restart_keyinput", 32'(keyinput), 0);
    w = 16'h1234;
    send_bits(w, 15, 0, 2);
    finish_load(w);
    chk("restart_load_key", 32'(keyinput), 32'h1234);
    chk("restart_load_kv", 32'(key_valid), 1);

    // Timeout: 5 bits then idle
    do_start(0);
    send_bits(16'hFFFF, 15, 11, 0);
    repeat (254) @(posedge clk);
    #2;
    chk("tmo_254_err", 32'(err), 0);
    chk("tmo_254_busy", 32'(busy), 1);
    @(posedge clk); #2;
    chk("tmo_255_err", 32'(err), 1);
    chk("tmo_keyinput", 32'(keyinput), 0);
    chk("tmo_busy", 32'(busy), 0);
    noise(5);
    chk("err_holds", 32'(err), 1);
    do_start(0);
    chk("start_clears_err", 32'(err), 0);

    // Start with a simultaneous bit: that bit is dropped
    w = 16'h5A0F;
    do_start(1);
    send_bits(w, 15, 1, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("discard_still_busy", 32'(busy), 1);
    chk("discard_kv_low", 32'(key_valid), 0);
    send_bits(w, 0, 0, 0);
    finish_load(w);
    chk("discard_key", 32'(keyinput), 32'h5A0F);

    // Reset mid-load
    do_start(0);
    send_bits(16'hBEEF, 15, 7, 0);
    @(negedge clk); rst_n = 0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_keyinput", 32'(keyinput), 0);
    chk("midrst_key_valid", 32'(key_valid), 0);
    chk("midrst_err", 32'(err), 0);
    @(negedge clk); rst_n = 1;
    noise(30);
    chk("nostart_keyinput", 32'(keyinput), 0);
    chk("nostart_busy", 32'(busy), 0);

    // Randomized loads: clean, timed-out, restarted, bad parity
    for (int r = 0; r < 40; r++) begin
      int mode = int'($urandom_range(0, 5));
      w = 16'($urandom);
      do_start(1'($urandom));
      case (mode)
        0, 1, 2: begin
          send_bits(w, 15, 0, 3);
          if (PAR_EN) send_par(1'($urandom));
        end
        3: begin
          send_bits(w, 15, int'($urandom_range(1, 15)), 2);
          repeat (TMO + 3) @(negedge clk);
        end
        4: begin
          send_bits(w, 15, int'($urandom_range(1, 15)), 2);
        end
        default: begin
          send_bits(w, 15, 8, 1);
          repeat (int'($urandom_range(TMO - 3, TMO - 1))) @(negedge clk);
          send_bits(w, 7, 0, 1);
        end
      endcase
      noise(int'($urandom_range(1, 6)));
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
